// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: fetch handshake, opcode decode into a type code,
// then execute / memory / writeback sequencing with PC update and trap reporting.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  output logic [31:0] ir_out,
  output logic [3:0]  instr_type,
  output logic        instr_type_wr_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        pc_wr_en,
  output logic        pc_sel,
  output logic        reg_wr_en,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;

  localparam int             CW       = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] T_NONE = 4'h0, T_R  = 4'h1, T_I   = 4'h2, T_LD = 4'h3,
                         T_JALR = 4'h4, T_SYS = 4'h5, T_ST = 4'h6, T_BR = 4'h7;

  function automatic logic [3:0] decode_op(input logic [6:0] op);
    case (op)
      7'b0110011: decode_op = T_R;
      7'b0010011: decode_op = T_I;
      7'b0000011: decode_op = T_LD;
      7'b1100111: decode_op = T_JALR;
      7'b1110011: decode_op = T_SYS;
      7'b0100011: decode_op = T_ST;
      7'b1100011: decode_op = T_BR;
      default:    decode_op = T_NONE;
    endcase
  endfunction

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pc_wr_q, pc_sel_q, br_exec;
  logic [3:0]      dec_type;

  assign dec_type = decode_op(ir_out[6:0]);

  // Branch direction and store completion are only known in their own cycle,
  // so those two cases bypass the output registers.
  assign pc_wr_en = pc_wr_q | (dmem_req & dmem_we & dmem_ack);
  assign pc_sel   = br_exec ? branch_taken : pc_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= FETCH;
      cnt              <= '0;
      imem_req         <= 1'b0;
      ir_out           <= '0;
      instr_type       <= T_NONE;
      instr_type_wr_en <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      pc_wr_q          <= 1'b0;
      pc_sel_q         <= 1'b0;
      br_exec          <= 1'b0;
      reg_wr_en        <= 1'b0;
      halted           <= 1'b0;
      trap             <= 1'b0;
      trap_cause       <= 2'b00;
    end else begin
      instr_type_wr_en <= 1'b0;
      pc_wr_q          <= 1'b0;
      pc_sel_q         <= 1'b0;
      br_exec          <= 1'b0;
      reg_wr_en        <= 1'b0;
      case (state)
        FETCH: begin
          // req low in FETCH only happens in the first cycle out of reset
          if (!imem_req) begin
            imem_req <= 1'b1;
            cnt      <= '0;
          end else if (imem_ack) begin
            ir_out           <= instr_in;
            imem_req         <= 1'b0;
            cnt              <= '0;
            instr_type_wr_en <= 1'b1;
            state            <= DECODE;
          end else if (cnt == CNT_LAST) begin
            imem_req   <= 1'b0;
            cnt        <= '0;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            state      <= TRAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          instr_type <= dec_type;
          if (dec_type == T_NONE) begin
            trap       <= 1'b1;
            trap_cause <= 2'b01;
            state      <= TRAP;
          end else begin
            state <= EXEC;
            if (dec_type == T_BR) begin
              pc_wr_q <= 1'b1;
              br_exec <= 1'b1;
            end
          end
        end
        EXEC: begin
          case (instr_type)
            T_R, T_I, T_JALR: begin
              reg_wr_en <= 1'b1;
              pc_wr_q   <= 1'b1;
              pc_sel_q  <= (instr_type == T_JALR);
              state     <= WB;
            end
            T_LD, T_ST: begin
              dmem_req <= 1'b1;
              dmem_we  <= (instr_type == T_ST);
              cnt      <= '0;
              state    <= MEM;
            end
            T_BR: begin
              imem_req <= 1'b1;
              cnt      <= '0;
              state    <= FETCH;
            end
            T_SYS: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: begin
              trap       <= 1'b1;
              trap_cause <= 2'b01;
              state      <= TRAP;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            cnt      <= '0;
            if (dmem_we) begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end else begin
              reg_wr_en <= 1'b1;
              pc_wr_q   <= 1'b1;
              state     <= WB;
            end
          end else if (cnt == CNT_LAST) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            cnt        <= '0;
            trap       <= 1'b1;
            trap_cause <= 2'b11;
            state      <= TRAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          imem_req <= 1'b1;
          cnt      <= '0;
          state    <= FETCH;
        end
        default: ; // HALT and TRAP hold until reset
      endcase
    end
  end

endmodule
